// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 4-stage pipeline: load-use interlock,
// taken-branch flush sequencing and data-memory wait with timeout.
module pipe_hazard_ctrl #(
    parameter logic [5:0]  NOP_OP     = 6'b110111,
    parameter int unsigned BR_PENALTY = 2,
    parameter int unsigned MEM_TMO    = 15
) (
    input  logic       clk,
    input  logic       rstd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_wreg,
    input  logic       ex_is_load,
    input  logic [4:0] wb_wreg,
    input  logic       br_taken,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       pc_stall,
    output logic       fd_stall,
    output logic       de_bubble,
    output logic       ew_hold,
    output logic       fd_flush,
    output logic [1:0] fwd_s,
    output logic [1:0] fwd_t,
    output logic       timeout_err,
    output logic [1:0] state_o
);

    localparam int unsigned FCNT_W = 2;
    localparam int unsigned WCNT_W = 8;
    localparam logic [FCNT_W-1:0] FLUSH_INIT   = FCNT_W'(BR_PENALTY - 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT   = WCNT_W'(MEM_TMO);
    localparam bit                SINGLE_FLUSH = (BR_PENALTY <= 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDUSE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MWAIT = 2'd3
    } state_t;

    state_t              state;
    logic [FCNT_W-1:0]   fcnt;
    logic [WCNT_W-1:0]   wcnt;
    logic                hz;
    logic                mem_miss;

    // Load-use interlock: register 0 is never a real dependency
    always_comb begin
        hz = ex_is_load && (ex_wreg != 5'd0) &&
             ((id_use_rs && (id_rs == ex_wreg)) || (id_use_rt && (id_rt == ex_wreg)));
        mem_miss = mem_req && !mem_ack;
    end

    // Control decode; LDUSE reacts like RUN except that it never re-stalls
    always_comb begin
        pc_stall  = 1'b0;
        fd_stall  = 1'b0;
        de_bubble = 1'b0;
        ew_hold   = 1'b0;
        fd_flush  = 1'b0;
        case (state)
            ST_RUN, ST_LDUSE: begin
                if (mem_miss) begin
                    ew_hold  = 1'b1;
                    pc_stall = 1'b1;
                    fd_stall = 1'b1;
                end else if (br_taken) begin
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                end else if ((state == ST_RUN) && hz) begin
                    pc_stall  = 1'b1;
                    fd_stall  = 1'b1;
                    de_bubble = 1'b1;
                end
            end
            ST_FLUSH: begin
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
            end
            ST_MWAIT: begin
                ew_hold  = 1'b1;
                pc_stall = 1'b1;
                fd_stall = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand forwarding from the EX/WB register
    assign fwd_s   = (id_use_rs && (id_rs != 5'd0) && (id_rs == wb_wreg)) ? 2'd1 : 2'd0;
    assign fwd_t   = (id_use_rt && (id_rt != 5'd0) && (id_rt == wb_wreg)) ? 2'd1 : 2'd0;
    assign state_o = state;

    // State, flush/wait counters and sticky timeout flag
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state       <= ST_RUN;
            fcnt        <= '0;
            wcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_LDUSE: begin
                    if (mem_miss) begin
                        state <= ST_MWAIT;
                        wcnt  <= WCNT_W'(1);
                    end else if (br_taken) begin
                        state <= SINGLE_FLUSH ? ST_RUN : ST_FLUSH;
                        fcnt  <= SINGLE_FLUSH ? '0 : FLUSH_INIT;
                    end else if ((state == ST_RUN) && hz) begin
                        state <= ST_LDUSE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (br_taken) begin
                        state <= SINGLE_FLUSH ? ST_RUN : ST_FLUSH;
                        fcnt  <= SINGLE_FLUSH ? '0 : FLUSH_INIT;
                    end else if (fcnt <= FCNT_W'(1)) begin
                        state <= ST_RUN;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                ST_MWAIT: begin
                    if (mem_ack) begin
                        state <= ST_RUN;
                        wcnt  <= '0;
                    end else if (wcnt >= WAIT_LIMIT) begin
                        state       <= ST_RUN;
                        wcnt        <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
